fb_port_arbiter: RTL

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter_pkg.sv | 24 ++
 rtl/fb_wr_fifo.sv | 73 +++++++
 rtl/fb_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_port_arbiter_pkg                                         |
// | Brief  : Shared constants and grant-state encoding for the frame-    |
// |          buffer port arbiter.                                        |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package fb_port_arbiter_pkg;

  // Active video geometry of the stored frame
  localparam int unsigned c_H_ACTIVE = 640;
  localparam int unsigned c_V_ACTIVE = 480;
  localparam int unsigned c_FB_WORDS = c_H_ACTIVE * c_V_ACTIVE;

  // Grant state: which port owns the single RAM port next cycle
  typedef enum logic [1:0] {
    GS_IDLE     = 2'd0,
    GS_RD       = 2'd1,
    GS_WR       = 2'd2,
    GS_FORCE_WR = 2'd3
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_wr_fifo                                                  |
// | Brief  : Camera write FIFO; each entry carries its frame-buffer      |
// |          address alongside the pixel so later address resets do not  |
// |          disturb queued pixels.                                      |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fb_wr_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_pop_addr,
  output logic [DATA_W-1:0] o_pop_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     w_push;
  logic                     w_pop;

  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Guard both ends so a stray request can never corrupt the queue
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign {o_pop_addr, o_pop_data} = r_mem[r_rd_ptr];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge pixclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_push_addr, i_push_data};
    end
  end

  // Pointers and occupancy; push+pop together leaves count unchanged
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fb_port_arbiter                                             |
// | Brief  : Shares one single-port frame-buffer RAM between a camera    |
// |          writer (via a small FIFO) and a display reader. Display     |
// |          reads win until the FIFO nears full, then writes are forced |
// |          until it drains to half the high-water mark.                |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int FB_WORDS = int'(c_FB_WORDS),
  parameter int WF_DEPTH = 16,
  parameter int WF_HIGH  = 12
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              cam_sof,
  output logic              cam_ready,
  input  logic              disp_req,
  input  logic              disp_sof,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ovf_err,
  output logic              urun_err
);

  localparam int                CNT_W       = $clog2(WF_DEPTH + 1);
  localparam logic [CNT_W-1:0]  c_HIGH      = CNT_W'(WF_HIGH);
  localparam logic [CNT_W-1:0]  c_LOW       = CNT_W'(WF_HIGH / 2);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  grant_e            r_state;
  grant_e            w_next;
  grant_e            w_normal;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_cam_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_rd_go;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_fifo_addr;
  logic [DATA_W-1:0] w_fifo_data;

  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_ovf_err;
  logic              r_urun_err;

  // Start-of-frame pulses rebase the address used by the same-cycle access
  assign w_cam_addr = cam_sof  ? '0 : r_wr_addr;
  assign w_rd_addr  = disp_sof ? '0 : r_rd_addr;

  assign w_push  = cam_valid & ~w_full;
  assign w_drop  = cam_valid & w_full;
  assign w_pop   = (w_next == GS_WR) || (w_next == GS_FORCE_WR);
  assign w_rd_go = (w_next == GS_RD);

  fb_wr_fifo #(
    .DEPTH  (WF_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_wr_fifo (
    .pixclk      (pixclk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (w_cam_addr),
    .i_push_data (cam_data),
    .i_pop       (w_pop),
    .o_pop_addr  (w_fifo_addr),
    .o_pop_data  (w_fifo_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Grant state register
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) r_state <= GS_IDLE;
    else       r_state <= w_next;
  end

  // Next grant: reads first, forced drain once the FIFO reaches high water
  always_comb begin
    w_normal = GS_IDLE;
    if (disp_req)      w_normal = GS_RD;
    else if (!w_empty) w_normal = GS_WR;
    w_next = w_normal;
    case (r_state)
      GS_FORCE_WR: if (w_count > c_LOW)   w_next = GS_FORCE_WR;
      default:     if (w_count >= c_HIGH) w_next = GS_FORCE_WR;
    endcase
  end

  // Write address advances for every camera pixel, kept or dropped
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_wr_addr <= '0;
    end else if (cam_valid) begin
      r_wr_addr <= (w_cam_addr == c_LAST_ADDR) ? '0 : w_cam_addr + ADDR_W'(1);
    end else if (cam_sof) begin
      r_wr_addr <= '0;
    end
  end

  // Read address advances only for granted display reads
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_rd_addr <= '0;
    end else if (w_rd_go) begin
      r_rd_addr <= (w_rd_addr == c_LAST_ADDR) ? '0 : w_rd_addr + ADDR_W'(1);
    end else if (disp_sof) begin
      r_rd_addr <= '0;
    end
  end

  // Registered RAM strobes for the access granted this cycle
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_en <= w_pop | w_rd_go;
      r_ram_we <= w_pop;
      if (w_pop) begin
        r_ram_addr  <= w_fifo_addr;
        r_ram_wdata <= w_fifo_data;
      end else if (w_rd_go) begin
        r_ram_addr  <= w_rd_addr;
      end
    end
  end

  // Capture read data during the read access cycle; data holds otherwise
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_disp_valid <= r_ram_en & ~r_ram_we;
      if (r_ram_en && !r_ram_we) r_disp_data <= ram_rdata;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_ovf_err  <= 1'b0;
      r_urun_err <= 1'b0;
    end else begin
      if (w_drop)                               r_ovf_err  <= 1'b1;
      if (disp_req && (w_next == GS_FORCE_WR))  r_urun_err <= 1'b1;
    end
  end

  assign cam_ready  = ~w_full;
  assign ram_en     = r_ram_en;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_data;
  assign ovf_err    = r_ovf_err;
  assign urun_err   = r_urun_err;

endmodule
`default_nettype wire
